// File: rtl/pci_defs.sv
// Shared definitions for the PCI initiator: FSM state encoding, completion kinds,
// PCI memory command codes and parameter defaults.
package pci_defs;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StData,
    StTurn,
    StBackoff
  } state_e;

  // Outcome of the data phase, carried through the turnaround cycle.
  typedef enum logic [1:0] {
    DoneOk,
    DoneRetry,
    DoneAbort
  } done_e;

  localparam logic [3:0] CMD_MEMRD = 4'b0110;
  localparam logic [3:0] CMD_MEMWR = 4'b0111;

  localparam int unsigned DEVSEL_TO_DEFAULT = 5;
  localparam int unsigned RETRIES_DEFAULT   = 15;

  function automatic logic [3:0] mem_cmd(input logic we);
    return we ? CMD_MEMWR : CMD_MEMRD;
  endfunction

endpackage

// File: rtl/pci_parity_gen.sv
// PCI PAR generator: registers the even parity of AD and C/BE# so PAR appears one
// clock after the cycle it covers, and delays the AD output enable to match.
// Ports:
//   clk_i, rst_ni  PCI clock, asynchronous active-low reset
//   ad_i, cbe_i    AD / C/BE# values driven this cycle
//   ad_oe_i        this block drives AD this cycle
//   par_o          parity of the previous cycle's AD and C/BE#
//   par_oe_o       PAR output enable (previous cycle's AD enable)
module pci_parity_gen (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ad_i,
  input  logic [3:0]  cbe_i,
  input  logic        ad_oe_i,
  output logic        par_o,
  output logic        par_oe_o
);

  logic par_q;
  logic par_oe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q    <= 1'b0;
      par_oe_q <= 1'b0;
    end else begin
      par_q    <= ^{ad_i, cbe_i};
      par_oe_q <= ad_oe_i;
    end
  end

  assign par_o    = par_q;
  assign par_oe_o = par_oe_q;

endmodule

// File: rtl/wb_pci_initiator.sv
// Single-data-phase PCI bus master. Accepts one local command at a time, requests
// the bus, runs the address phase and one data phase, and handles target retry,
// disconnect and master abort. Bus pins are presented as output/enable pairs; the
// pad ring owns the tri-states.
// Optional feature: define PCI_INITIATOR_PARITY_EN to add pci_par_o/pci_par_oe_o.
// Without it there are no parity ports and the top level ties PAR to high-Z.
// Ports:
//   pci_clk_i, pci_rst_ni          clock, asynchronous active-low reset
//   pci_gnt_ni / pci_req_no        arbiter grant / bus request
//   pci_*_ni, pci_ad_i             sampled bus controls and AD
//   pci_frame_no/oe, pci_irdy_no/oe, pci_ad_o/oe, pci_cbe_no/oe   driven bus signals
//   req_i, we_i, addr_i, be_i, dat_i   local command (held until ack_o)
//   dat_o, ack_o, err_o            completion: read data, done pulse, failure pulse
module wb_pci_initiator
  import pci_defs::*;
#(
  parameter int unsigned RETRIES   = RETRIES_DEFAULT,
  parameter int unsigned DEVSEL_TO = DEVSEL_TO_DEFAULT
) (
  input  logic        pci_clk_i,
  input  logic        pci_rst_ni,
  input  logic        pci_gnt_ni,
  output logic        pci_req_no,
  input  logic        pci_frame_ni,
  input  logic        pci_irdy_ni,
  input  logic        pci_trdy_ni,
  input  logic        pci_devsel_ni,
  input  logic        pci_stop_ni,
  input  logic [31:0] pci_ad_i,
  output logic        pci_frame_no,
  output logic        pci_frame_oe_o,
  output logic        pci_irdy_no,
  output logic        pci_irdy_oe_o,
  output logic [31:0] pci_ad_o,
  output logic        pci_ad_oe_o,
  output logic [3:0]  pci_cbe_no,
  output logic        pci_cbe_oe_o,
`ifdef PCI_INITIATOR_PARITY_EN
  output logic        pci_par_o,
  output logic        pci_par_oe_o,
`endif
  input  logic        req_i,
  input  logic        we_i,
  input  logic [29:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam logic [2:0] DevselTo = 3'(DEVSEL_TO);
  localparam logic [3:0] RetryMax = 4'(RETRIES);

  state_e      state_q, state_d;
  done_e       done_q, done_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;
  logic        accept;

  // Latched command; local inputs are ignored while a command is in flight.
  logic        we_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdat_q;

  always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
    if (!pci_rst_ni) begin
      state_q <= StIdle;
      done_q  <= DoneOk;
      cnt_q   <= '0;
      retry_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      if (accept) begin
        we_q   <= we_i;
        addr_q <= addr_i;
        be_q   <= be_i;
        wdat_q <= dat_i;
      end
    end
  end

  // Next-state logic. cnt_q times DEVSEL# in DATA and the idle clocks in BACKOFF.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // ack_q high means this is the completion cycle; req_i is still held then.
        if (req_i && !ack_q) begin
          accept  = 1'b1;
          retry_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!pci_gnt_ni && pci_frame_ni && pci_irdy_ni) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        if (!pci_trdy_ni) begin
          // Covers disconnect-with-data too: STOP# alongside TRDY# still transfers.
          done_d  = DoneOk;
          state_d = StTurn;
          if (!we_q) begin
            rdat_d = pci_ad_i;
          end
        end else if (!pci_stop_ni) begin
          done_d  = DoneRetry;
          state_d = StTurn;
        end else if (pci_devsel_ni && (cnt_q == DevselTo)) begin
          done_d  = DoneAbort;
          state_d = StTurn;
        end else if (cnt_q != DevselTo) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StTurn: begin
        if (done_q == DoneRetry) begin
          cnt_d   = '0;
          state_d = StBackoff;
        end else begin
          ack_d   = 1'b1;
          err_d   = (done_q == DoneAbort);
          state_d = StIdle;
        end
      end
      StBackoff: begin
        if (cnt_q == 3'd1) begin
          if (retry_q + 4'd1 == RetryMax) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            retry_d = '0;
            state_d = StIdle;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = StReq;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus drive decoded straight from state so an asynchronous reset releases the
  // bus without waiting for a clock.
  always_comb begin
    pci_req_no     = 1'b1;
    pci_frame_no   = 1'b1;
    pci_frame_oe_o = 1'b0;
    pci_irdy_no    = 1'b1;
    pci_irdy_oe_o  = 1'b0;
    pci_ad_o       = '0;
    pci_ad_oe_o    = 1'b0;
    pci_cbe_no     = 4'hF;
    pci_cbe_oe_o   = 1'b0;
    unique case (state_q)
      StReq: pci_req_no = 1'b0;
      StAddr: begin
        pci_frame_no   = 1'b0;
        pci_frame_oe_o = 1'b1;
        pci_ad_o       = {addr_q, 2'b00};
        pci_ad_oe_o    = 1'b1;
        pci_cbe_no     = mem_cmd(we_q);
        pci_cbe_oe_o   = 1'b1;
      end
      StData: begin
        // FRAME# deasserted but still driven: this is the last data phase.
        pci_frame_oe_o = 1'b1;
        pci_irdy_no    = 1'b0;
        pci_irdy_oe_o  = 1'b1;
        pci_cbe_no     = ~be_q;
        pci_cbe_oe_o   = 1'b1;
        pci_ad_o       = wdat_q;
        pci_ad_oe_o    = we_q;
      end
      StTurn: pci_irdy_oe_o = 1'b1;
      default: ;
    endcase
  end

  assign dat_o = rdat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

`ifdef PCI_INITIATOR_PARITY_EN
  pci_parity_gen u_parity (
    .clk_i   (pci_clk_i),
    .rst_ni  (pci_rst_ni),
    .ad_i    (pci_ad_o),
    .cbe_i   (pci_cbe_no),
    .ad_oe_i (pci_ad_oe_o),
    .par_o   (pci_par_o),
    .par_oe_o(pci_par_oe_o)
  );
`endif

endmodule

// File: tb/tb_wb_pci_initiator.sv
// Directed bench for wb_pci_initiator. Bus-phase checks are made inline; command
// completions are checked by a scoreboard monitor that pops on every ack_o.
module tb_wb_pci_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gnt_n, frame_n, irdy_n, trdy_n, devsel_n, stop_n;
  logic [31:0] ad_in;
  logic        req, we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdat;

  logic        req_no, frame_no, frame_oe, irdy_no, irdy_oe, ad_oe, cbe_oe;
  logic [31:0] ad_o, dat_o;
  logic [3:0]  cbe_no;
  logic        ack_o, err_o;
`ifdef PCI_INITIATOR_PARITY_EN
  logic        par, par_oe;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        chk_dat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_pci_initiator #(.RETRIES(3), .DEVSEL_TO(5)) dut (
    .pci_clk_i     (clk),
    .pci_rst_ni    (rst_n),
    .pci_gnt_ni    (gnt_n),
    .pci_req_no    (req_no),
    .pci_frame_ni  (frame_n),
    .pci_irdy_ni   (irdy_n),
    .pci_trdy_ni   (trdy_n),
    .pci_devsel_ni (devsel_n),
    .pci_stop_ni   (stop_n),
    .pci_ad_i      (ad_in),
    .pci_frame_no  (frame_no),
    .pci_frame_oe_o(frame_oe),
    .pci_irdy_no   (irdy_no),
    .pci_irdy_oe_o (irdy_oe),
    .pci_ad_o      (ad_o),
    .pci_ad_oe_o   (ad_oe),
    .pci_cbe_no    (cbe_no),
    .pci_cbe_oe_o  (cbe_oe),
`ifdef PCI_INITIATOR_PARITY_EN
    .pci_par_o     (par),
    .pci_par_oe_o  (par_oe),
`endif
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .be_i          (be),
    .dat_i         (wdat),
    .dat_o         (dat_o),
    .ack_o         (ack_o),
    .err_o         (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected ack", ack_o, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack err", err_o, e.err);
        if (e.chk_dat) chk("ack rdata", dat_o, e.dat);
      end
    end else if (rst_n === 1'b1 && err_o !== 1'b0) begin
      chk("err without ack", err_o, 0);
    end
  end

`ifdef PCI_INITIATOR_PARITY_EN
  logic prev_oe = 1'b0;
  logic prev_par = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_oe = 1'b0;
    end else begin
      chk("par oe", par_oe, prev_oe);
      if (prev_oe) chk("par value", par, prev_par);
      prev_oe  = ad_oe;
      prev_par = ^{ad_o, cbe_no};
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tgt(input logic dv, input logic tr, input logic st, input logic [31:0] d);
    devsel_n = dv;
    trdy_n   = tr;
    stop_n   = st;
    ad_in    = d;
  endtask

  task automatic issue(input logic w, input logic [29:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic push, input logic e_err,
                       input logic [31:0] e_dat, input logic e_chk);
    exp_t e;
    we = w; addr = a; be = b; wdat = d; req = 1'b1;
    if (push) begin
      e.err = e_err; e.dat = e_dat; e.chk_dat = e_chk;
      sb.push_back(e);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (req_no !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk({name, " req asserted"}, req_no, 0);
  endtask

  // From REQ: grant, land in ADDR and check it, then drop GNT#.
  task automatic grant(input string name, input logic [31:0] e_ad, input logic [3:0] e_cbe);
    gnt_n = 1'b0;
    step();
    chk({name, " addr frame"}, {frame_no, frame_oe}, 2'b01);
    chk({name, " addr ad"}, ad_o, e_ad);
    chk({name, " addr cbe"}, {ad_oe, cbe_oe, cbe_no}, {2'b11, e_cbe});
    chk({name, " addr req released"}, req_no, 1);
    gnt_n = 1'b1;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (ack_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({name, " ack seen"}, ack_o, 1);
    chk({name, " irdy released"}, irdy_oe, 0);
    req = 1'b0;
    step();
    chk({name, " ack one cycle"}, ack_o, 0);
  endtask

  task automatic check_turn(input string name);
    chk({name, " turn"}, {irdy_no, irdy_oe, frame_oe, ad_oe, cbe_oe}, 5'b11000);
  endtask

  // From REQ: one attempt that the target retries, through BACKOFF back to REQ.
  task automatic retry_attempt(input string name, input logic [31:0] e_ad, input logic [3:0] e_cbe);
    grant(name, e_ad, e_cbe);
    tgt(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk({name, " data irdy"}, irdy_no, 0);
    step();
    check_turn(name);
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    step();
    chk({name, " backoff1"}, {req_no, frame_oe, ack_o}, 3'b100);
    step();
    chk({name, " backoff2"}, {req_no, frame_oe, ack_o}, 3'b100);
    step();
    chk({name, " re-request"}, req_no, 0);
  endtask

  initial begin
    gnt_n = 1; frame_n = 1; irdy_n = 1;
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    req = 0; we = 0; addr = '0; be = '0; wdat = '0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset oe", {frame_oe, irdy_oe, ad_oe, cbe_oe}, 4'b0000);
    chk("reset pins", {req_no, frame_no, irdy_no}, 3'b111);
    chk("reset ack/err", {ack_o, err_o}, 2'b00);
    chk("reset dat", dat_o, 0);
    rst_n = 1'b1;
    step();

    // Write, target claims and completes on the first data clock.
    issue(1'b1, 30'h400, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    wait_req("wr");
    grant("wr", 32'h0000_1000, 4'b0111);
    tgt(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("wr data ad", {ad_oe, ad_o}, {1'b1, 32'hDEADBEEF});
    chk("wr data cbe", cbe_no, 4'b0000);
    chk("wr data ctl", {frame_no, frame_oe, irdy_no, irdy_oe}, 4'b1101);
    step();
    check_turn("wr");
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    wait_ack("wr");

    // Read with three wait states.
    issue(1'b0, 30'h4, 4'h3, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h12345678, 1'b1);
    wait_req("rd");
    grant("rd", 32'h0000_0010, 4'b0110);
    tgt(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd data ad_oe low", {ad_oe, irdy_no, cbe_no}, {2'b00, 4'b1100});
    end
    tgt(1'b0, 1'b0, 1'b1, 32'h12345678);
    step();
    check_turn("rd");
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    wait_ack("rd");

    // Master abort: no DEVSEL#, six data clocks then turnaround.
    issue(1'b0, 30'h8, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    wait_req("abort");
    grant("abort", 32'h0000_0020, 4'b0110);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort data wait", {irdy_no, frame_oe, ack_o}, 3'b010);
    end
    step();
    check_turn("abort");
    wait_ack("abort");
    chk("abort keeps rdata", dat_o, 32'h12345678);

    // Two retries then success (RETRIES = 3).
    step();
    issue(1'b1, 30'h10, 4'hF, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    wait_req("rty");
    retry_attempt("rty1", 32'h0000_0040, 4'b0111);
    retry_attempt("rty2", 32'h0000_0040, 4'b0111);
    grant("rty3", 32'h0000_0040, 4'b0111);
    tgt(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("rty3 data ad", ad_o, 32'hA5A5A5A5);
    step();
    check_turn("rty3");
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    wait_ack("rty");

    // Permanent retry: third retry exhausts the budget.
    issue(1'b0, 30'h20, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    wait_req("exh");
    retry_attempt("exh1", 32'h0000_0080, 4'b0110);
    retry_attempt("exh2", 32'h0000_0080, 4'b0110);
    grant("exh3", 32'h0000_0080, 4'b0110);
    tgt(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    check_turn("exh3");
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    step();
    step();
    chk("exh backoff no ack", ack_o, 0);
    step();
    chk("exh no re-request", req_no, 1);
    wait_ack("exh");

    // Bus busy and GNT# toggling keep the master in REQ.
    issue(1'b1, 30'h40, 4'h5, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0, 1'b0);
    wait_req("busy");
    frame_n = 1'b0; gnt_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy frame low", {req_no, frame_oe}, 2'b00);
    end
    frame_n = 1'b1; irdy_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("busy irdy low", {req_no, frame_oe}, 2'b00);
    end
    irdy_n = 1'b1; gnt_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("no gnt", {req_no, frame_oe}, 2'b00);
    end
    grant("busy", 32'h0000_0100, 4'b0111);
    tgt(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("busy data cbe", {cbe_no, ad_o}, {4'b1010, 32'h0F0F0F0F});
    step();
    check_turn("busy");
    tgt(1'b1, 1'b1, 1'b1, 32'h0);
    wait_ack("busy");

    // Asynchronous reset in the middle of a data phase: no completion.
    issue(1'b1, 30'h80, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_req("rst");
    grant("rst", 32'h0000_0200, 4'b0111);
    step();
    chk("rst in data", irdy_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async oe", {frame_oe, irdy_oe, ad_oe, cbe_oe}, 4'b0000);
    chk("rst async req", req_no, 1);
    req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst no ack", {ack_o, frame_oe, req_no}, 3'b001);
    end
    chk("rst dat cleared", dat_o, 0);

    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
